binary_decoder_stream: RTL and testbench

Streaming 4-to-16 binary-to-one-hot decoder: the decode side of the 16-to-4 encoder path. It accepts 4-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO. It presents each code as a 16-bit one-hot word over a second valid/ready handshake and keeps a saturating count of delivered words. The block sits downstream of the encoder in the TMRG SystemVerilog test suite and is triplicated by default (`tmrg default triplicate`).

---
 rtl/binary_decoder_stream_if.sv | 37 +++
 rtl/binary_decoder_stream.sv | 108 ++++++++++
 tb/tb_binary_decoder_stream.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/binary_decoder_stream_if.sv
// Handshake bundle for the streaming binary-to-one-hot decoder.
// Both channels use the same valid/ready rule. A transfer happens on a rising
// clk edge where valid && ready are both high. The source holds its data
// stable while valid=1 and ready=0. The sink may raise or lower ready at any
// time. The upstream source here may drop in_valid without a transfer.
interface binary_decoder_stream_if #(
  parameter int CODE_W = 4
);
  localparam int OH_W = 1 << CODE_W;

  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic              in_ready;
  logic [OH_W-1:0]   out_onehot;
  logic              out_valid;
  logic              out_ready;

  // Decoder side: consumes codes, produces one-hot words.
  modport slave (
    input  in_code,
    input  in_valid,
    output in_ready,
    output out_onehot,
    output out_valid,
    input  out_ready
  );

  // Environment side: produces codes, consumes one-hot words.
  modport master (
    output in_code,
    output in_valid,
    input  in_ready,
    input  out_onehot,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/binary_decoder_stream.sv
// Streaming 4-to-16 binary-to-one-hot decoder.
// Codes are buffered in a small FIFO. The head entry is decoded
// combinationally onto out_onehot. A saturating counter tracks how many
// output words have been delivered.
// in_ready comes only from the registered fill count, so there is no
// combinational path from out_ready to in_ready.
module binary_decoder_stream #(
  parameter int CODE_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  binary_decoder_stream_if.slave   bus,
  input  logic                     enable,
  output logic [CNT_W-1:0]         xfer_count
);
  localparam int OH_W   = 1 << CODE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;

  logic              push;
  logic              pop;
  logic              in_ready_w;
  logic              out_valid_w;
  logic [CODE_W-1:0] head_code;

  // Handshake qualifiers come from registered fill state only.
  always_comb begin
    in_ready_w  = (count_q != FILL_W'(DEPTH));
    out_valid_w = (count_q != '0);
    push        = bus.in_valid && in_ready_w;
    pop         = out_valid_w && bus.out_ready;
  end

  // Next-state for pointers, fill count and the saturating delivery counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (xfer_q != '1) begin
        xfer_d = xfer_q + 1'b1;
      end
    end
    // A push and a pop in the same cycle cancel, so the count is unchanged.
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer, count and counter registers; reset discards all buffered codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xfer_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
    end
  end

  // FIFO storage; only the slot at the write pointer is written on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.in_code;
    end
  end

  // Head decode. The word is forced to zero when the FIFO is empty, so that
  // stale storage never appears on the bus. It is also forced to zero when
  // enable is low. enable masks data only and does not affect the handshake.
  always_comb begin
    head_code      = mem_q[rd_ptr_q];
    bus.out_onehot = '0;
    if (enable && out_valid_w) begin
      bus.out_onehot = {{(OH_W-1){1'b0}}, 1'b1} << head_code;
    end
  end

  // Drive the handshake status and the counter outputs.
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.out_valid = out_valid_w;
    xfer_count    = xfer_q;
  end
endmodule

// File: tb/tb_binary_decoder_stream.sv
// Directed and random checks of the streaming decoder against a queue model.
module tb_binary_decoder_stream;
  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] xfer_count;

  int checks = 0;
  int errors = 0;
  int m_xfer = 0;
  logic [15:0] exp_q[$];

  binary_decoder_stream_if #(.CODE_W(4)) bus ();

  binary_decoder_stream #(.CODE_W(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .enable     (enable),
    .xfer_count (xfer_count)
  );

  // Clock: 10 time-unit period, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The inputs were driven before this call. Outputs are
  // sampled at the falling edge. The model is then updated with whatever
  // transfers the rising edge performs.
  task automatic cycle();
    logic [15:0] exp_oh;
    bit push, pop;
    @(negedge clk);
    exp_oh = (exp_q.size() != 0 && enable) ? exp_q[0] : 16'h0000;
    check("in_ready",   32'(bus.in_ready),  32'(exp_q.size() != 2));
    check("out_valid",  32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("out_onehot", 32'(bus.out_onehot), 32'(exp_oh));
    check("xfer_count", 32'(xfer_count),    32'(m_xfer));
    push = bus.in_valid && (exp_q.size() != 2);
    pop  = (exp_q.size() != 0) && bus.out_ready;
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      if (m_xfer < 255) m_xfer++;
    end
    if (push) exp_q.push_back(16'h0001 << bus.in_code);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] code, input bit rdy);
    bus.in_valid  = v;
    bus.in_code   = code;
    bus.out_ready = rdy;
  endtask

  initial begin
    // Power-up reset.
    rst_n = 1'b1;
    enable = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_onehot", 32'(bus.out_onehot), 32'h0);
    check("rst_xfer",       32'(xfer_count),     32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single decode of 4'hA.
    drive(1'b1, 4'hA, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 1'b1);
    cycle();
    cycle();

    // Sweep all codes back-to-back.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 4'h0, 1'b1);
    cycle();
    cycle();
    check("sweep_xfer", 32'(xfer_count), 32'd17);

    // Backpressure: fill with 3 and F. The third push (7) must be ignored.
    drive(1'b1, 4'h3, 1'b0);
    cycle();
    drive(1'b1, 4'hF, 1'b0);
    cycle();
    drive(1'b1, 4'h7, 1'b0);
    cycle();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 4'h0, 1'b1);
    repeat (3) cycle();

    // Full with a simultaneous pop: the push is refused and in_ready rises later.
    drive(1'b1, 4'h1, 1'b0);
    cycle();
    drive(1'b1, 4'h2, 1'b0);
    cycle();
    drive(1'b1, 4'h4, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 1'b1);
    repeat (3) cycle();

    // Enable masking: the entry is consumed and the counter still advances.
    enable = 1'b0;
    drive(1'b1, 4'h5, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 1'b1);
    cycle();
    enable = 1'b1;
    drive(1'b1, 4'h9, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 1'b1);
    repeat (2) cycle();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      enable = ($urandom_range(0, 3) != 0);
      cycle();
    end
    enable = 1'b1;

    // Saturation: stream enough words to pass 255 deliveries.
    for (int i = 0; i < 265; i++) begin
      drive(1'b1, 4'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 4'h0, 1'b1);
    repeat (3) cycle();
    check("xfer_saturated", 32'(xfer_count), 32'd255);

    // Asynchronous reset with two codes buffered.
    drive(1'b1, 4'h6, 1'b0);
    cycle();
    drive(1'b1, 4'hC, 1'b0);
    cycle();
    drive(1'b0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("mid_rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("mid_rst_out_onehot", 32'(bus.out_onehot), 32'h0);
    check("mid_rst_xfer",       32'(xfer_count),     32'd0);
    exp_q.delete();
    m_xfer = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First push right after reset release; nothing old may reappear.
    drive(1'b1, 4'hE, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 1'b1);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
